// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit round-robin arbiter.
//   arb_state_e : arbiter FSM states (idle / start held / waiting for busy to fall)
//   ID_W        : width of a requester index
//   BYTE_W      : width of one UART byte
//   wrap_inc    : index + 1 modulo a requester count
package uart_ctrl_pkg;

  localparam int unsigned ID_W   = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitDone = 2'd2
  } arb_state_e;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int unsigned n);
    logic [ID_W:0] nxt;
    nxt = {1'b0, idx} + (ID_W+1)'(1);
    if (32'(nxt) >= n) begin
      nxt = '0;
    end
    return nxt[ID_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the UART transmitter.
//   req/req_data/req_last : per-requester byte offer (producer -> arbiter)
//   gnt                   : one-hot byte-consumed pulse (arbiter -> producer)
//   tx_start/tx_data      : UART transmit command (arbiter -> UART)
//   tx_busy               : UART transmitter busy (UART -> arbiter)
//   owner_valid/owner_id  : current owner status
//   err_start_to/lock_to  : timeout pulses
// modport master is the arbiter side, slave the surrounding environment.
interface uart_tx_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import uart_ctrl_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        gnt;
  logic                    tx_start;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    owner_valid;
  logic [ID_W-1:0]         owner_id;
  logic                    err_start_to;
  logic                    err_lock_to;

  modport master (
    input  req, req_data, req_last, tx_busy,
    output gnt, tx_start, tx_data, owner_valid, owner_id, err_start_to, err_lock_to
  );

  modport slave (
    output req, req_data, req_last, tx_busy,
    input  gnt, tx_start, tx_data, owner_valid, owner_id, err_start_to, err_lock_to
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational requester selection.
//   req   : request mask
//   ptr   : round-robin start index (< N_REQ)
//   lock  : packet lock active; only the owner may win
//   owner : locked owner index
//   found : some eligible request exists
//   idx   : winning index
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             lock,
  input  logic [ID_W-1:0]  owner,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;
  logic               owner_req;

  always_comb begin
    // Rotating a doubled mask puts request (ptr + k) mod N_REQ at bit k.
    req_dbl = {req, req};
    rot     = N_REQ'(req_dbl >> ptr);

    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = ID_W'(k);
      end
    end

    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W+1)'(N_REQ)) begin
      sum = sum - (ID_W+1)'(N_REQ);
    end

    owner_req = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == ID_W'(k)) begin
        owner_req = req[k];
      end
    end

    found = lock ? owner_req : |rot;
    idx   = lock ? owner : sum[ID_W-1:0];
  end

endmodule

// File: rtl/uart_tx_rr_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers.
// Round-robin per byte; a byte with req_last=0 locks the transmitter to its producer until a
// byte with req_last=1 is sent or the owner stays idle for LOCK_TO cycles. tx_start is held
// until tx_busy rises, or dropped with err_start_to after START_TO further cycles.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : arbiter side of uart_tx_rr_arbiter_if
module uart_tx_rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned START_TO = 4095,
  parameter int unsigned LOCK_TO  = 65535
) (
  input logic                  clk,
  input logic                  rst,
  uart_tx_rr_arbiter_if.master bus
);

  localparam int unsigned START_CW = $clog2(START_TO + 1);
  localparam int unsigned LOCK_CW  = $clog2(LOCK_TO + 1);
  localparam logic [START_CW-1:0] START_MAX = START_CW'(START_TO);
  localparam logic [LOCK_CW-1:0]  LOCK_MAX  = LOCK_CW'(LOCK_TO);

  arb_state_e state_q, state_d;

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [START_CW-1:0] start_cnt_q, start_cnt_d;
  logic [LOCK_CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                owner_valid_q, owner_valid_d;
  logic                err_start_q, err_start_d;
  logic                err_lock_q, err_lock_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            grant_go;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .lock  (lock_q),
    .owner (owner_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Busy while idle means someone else is using the UART: hold off.
  assign grant_go = (state_q == StIdle) && pick_found && !bus.tx_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_go) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (start_cnt_q == START_MAX) begin
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    lock_d        = lock_q;
    owner_d       = owner_q;
    start_cnt_d   = start_cnt_q;
    lock_cnt_d    = lock_cnt_q;
    gnt_d         = '0;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    owner_valid_d = owner_valid_q;
    err_start_d   = 1'b0;
    err_lock_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_go) begin
          gnt_d = N_REQ'(1) << pick_idx;
          for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == ID_W'(k)) begin
              tx_data_d = bus.req_data[BYTE_W*k +: BYTE_W];
              lock_d    = ~bus.req_last[k];
            end
          end
          owner_d       = pick_idx;
          ptr_d         = wrap_inc(pick_idx, N_REQ);
          tx_start_d    = 1'b1;
          owner_valid_d = 1'b1;
          start_cnt_d   = '0;
        end else if (lock_q) begin
          if (lock_cnt_q == LOCK_MAX) begin
            err_lock_d    = 1'b1;
            lock_d        = 1'b0;
            owner_valid_d = 1'b0;
            lock_cnt_d    = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_CW'(1);
          end
        end
      end
      StStart: begin
        if (bus.tx_busy) begin
          tx_start_d  = 1'b0;
          start_cnt_d = '0;
        end else if (start_cnt_q == START_MAX) begin
          // Transmitter never answered: abandon the byte and any packet lock.
          tx_start_d    = 1'b0;
          err_start_d   = 1'b1;
          lock_d        = 1'b0;
          owner_valid_d = 1'b0;
          start_cnt_d   = '0;
        end else begin
          start_cnt_d = start_cnt_q + START_CW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          owner_valid_d = lock_q;
          lock_cnt_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      lock_q        <= 1'b0;
      owner_q       <= '0;
      start_cnt_q   <= '0;
      lock_cnt_q    <= '0;
      gnt_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      owner_valid_q <= 1'b0;
      err_start_q   <= 1'b0;
      err_lock_q    <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      lock_q        <= lock_d;
      owner_q       <= owner_d;
      start_cnt_q   <= start_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      gnt_q         <= gnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      owner_valid_q <= owner_valid_d;
      err_start_q   <= err_start_d;
      err_lock_q    <= err_lock_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.owner_valid  = owner_valid_q;
  assign bus.owner_id     = owner_q;
  assign bus.err_start_to = err_start_q;
  assign bus.err_lock_to  = err_lock_q;

endmodule
